// File: rtl/store_queue_if.sv
// Store queue bus: execute-side store requests, memory-side write port and status.
// master = requester / memory model side, slave = the queue itself.
interface store_queue_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_ctrl;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        empty;
    logic        misalign_err;

    modport master (
        output req_valid, req_addr, req_data, req_ctrl, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, empty, misalign_err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_ctrl, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, empty, misalign_err
    );
endinterface

// File: rtl/store_queue.sv
// store_queue: formats sb/sh/sw stores into lane-replicated data plus byte strobes,
// buffers them in a DEPTH-entry FIFO and drains them to data memory over valid/ready.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word stores are accepted but dropped,
// with a one-cycle misalign_err pulse. Without it, misalign_err is tied 0.
module store_queue #(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    store_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    entry_t        fmt;
    logic          acc, deq, push;
    logic          unused_ctrl;

    // funct3[2] only selects signedness for loads; stores never look at it
    assign unused_ctrl = bus.req_ctrl[2];

    // Lane replication and strobe generation, applied before the entry is stored
    always_comb begin
        fmt.addr = {bus.req_addr[31:2], 2'b00};
        case (bus.req_ctrl[1:0])
            2'b00: begin
                fmt.wdata = {4{bus.req_data[7:0]}};
                fmt.wstrb = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                fmt.wdata = {2{bus.req_data[15:0]}};
                fmt.wstrb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                fmt.wdata = bus.req_data;
                fmt.wstrb = 4'b1111;
            end
        endcase
    end

    assign acc = bus.req_valid && bus.req_ready;
    assign deq = bus.mem_valid && bus.mem_ready;

`ifdef MISALIGN_TRAP_EN
    logic misaligned, misalign_q;

    assign misaligned = ((bus.req_ctrl[1:0] == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_ctrl[1] && (bus.req_addr[1:0] != 2'b00));
    assign push = acc && !misaligned;

    // Error pulse lands in the cycle after the dropped store is handshaken
    always_ff @(posedge clk) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= acc && misaligned;
    end
    assign bus.misalign_err = misalign_q;
`else
    assign push = acc;
    assign bus.misalign_err = 1'b0;
`endif

    // Pointer and occupancy next state; simultaneous push/pop leaves count alone
    always_comb begin
        rd_ptr_d = deq  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !deq)      count_d = count_q + (AW + 1)'(1);
        else if (!push && deq) count_d = count_q - (AW + 1)'(1);
    end

    // Queue state; entry storage needs no reset since outputs are masked when empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) fifo_q[wr_ptr_q] <= fmt;
        end
    end

    // Full blocks requests even if the head drains this cycle: no pass-through
    assign bus.req_ready = (count_q != FULL);
    assign bus.mem_valid = (count_q != '0);
    assign bus.empty     = (count_q == '0);
    assign bus.mem_addr  = bus.mem_valid ? fifo_q[rd_ptr_q].addr  : 32'h0;
    assign bus.mem_wdata = bus.mem_valid ? fifo_q[rd_ptr_q].wdata : 32'h0;
    assign bus.mem_wstrb = bus.mem_valid ? fifo_q[rd_ptr_q].wstrb : 4'h0;
endmodule

// File: tb/tb_store_queue.sv
// Testbench for store_queue: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model of formatted stores.
module tb_store_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_queue_if bus();

    store_queue #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    ent_t mq[$];
    logic exp_err = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference formatting from the store-size rules, using plain arithmetic
    function automatic ent_t fmt(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] ctrl);
        ent_t e;
        int   sz = int'(ctrl) % 4;
        int   off = int'(addr % 4);
        e.a = addr - (addr % 4);
        if (sz == 0) begin
            e.d = (data & 32'hFF) * 32'h01010101;
            e.s = 4'(1 << off);
        end else if (sz == 1) begin
            e.d = (data & 32'hFFFF) * 32'h00010001;
            e.s = (off >= 2) ? 4'hC : 4'h3;
        end else begin
            e.d = data;
            e.s = 4'hF;
        end
        return e;
    endfunction

    function automatic bit is_mis(input logic [31:0] addr, input logic [2:0] ctrl);
        int sz = int'(ctrl) % 4;
        return (sz == 1 && addr % 2 != 0) || (sz >= 2 && addr % 4 != 0);
    endfunction

    task automatic check_outputs();
        chk("mem_valid", 32'(bus.mem_valid), 32'(mq.size() != 0));
        chk("req_ready", 32'(bus.req_ready), 32'(mq.size() != DEPTH));
        chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("misalign_err", 32'(bus.misalign_err), 32'(exp_err));
        if (mq.size() != 0) begin
            chk("mem_addr", bus.mem_addr, mq[0].a);
            chk("mem_wdata", bus.mem_wdata, mq[0].d);
            chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(mq[0].s));
        end else begin
            chk("idle_addr", bus.mem_addr, 32'h0);
            chk("idle_wdata", bus.mem_wdata, 32'h0);
            chk("idle_wstrb", 32'(bus.mem_wstrb), 32'h0);
        end
    endtask

    // One clock: check at negedge, predict the edge, advance the model, settle #1
    task automatic cycle();
        bit   acc, deq, trap;
        ent_t e;
        @(negedge clk);
        check_outputs();
        acc = bus.req_valid && (mq.size() != DEPTH);
        deq = bus.mem_ready && (mq.size() != 0);
        e = fmt(bus.req_addr, bus.req_data, bus.req_ctrl);
`ifdef MISALIGN_TRAP_EN
        trap = is_mis(bus.req_addr, bus.req_ctrl);
`else
        trap = 1'b0;
`endif
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            exp_err = 1'b0;
        end else begin
            if (deq) void'(mq.pop_front());
            if (acc && !trap) mq.push_back(e);
            exp_err = acc && trap;
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] c);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_ctrl  = c;
    endtask

    initial begin
        // Reset held with a pending request: nothing may be captured
        drive(1'b1, 32'h1003, 32'hAABBCCDD, 3'b000);
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        cycle();
        cycle();
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        rst_n = 1'b1;

        // sb into byte lane 3
        drive(1'b1, 32'h1003, 32'hAABBCCDD, 3'b000);
        cycle();
        chk("sb_addr", bus.mem_addr, 32'h1000);
        chk("sb_wdata", bus.mem_wdata, 32'hDDDDDDDD);
        chk("sb_wstrb", 32'(bus.mem_wstrb), 32'h8);

        // sh into upper half, then sw
        drive(1'b1, 32'h2002, 32'h12345678, 3'b001);
        cycle();
        chk("sh_wdata", bus.mem_wdata, 32'h56785678);
        chk("sh_wstrb", 32'(bus.mem_wstrb), 32'hC);
        drive(1'b1, 32'h2004, 32'hCAFEF00D, 3'b010);
        cycle();
        chk("sw_addr", bus.mem_addr, 32'h2004);
        chk("sw_wdata", bus.mem_wdata, 32'hCAFEF00D);
        chk("sw_wstrb", 32'(bus.mem_wstrb), 32'hF);
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        repeat (2) cycle();

        // Fill with memory stalled; 5th request must be held off
        bus.mem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h4000 + 32'(4 * i), 32'h100 + 32'(i), 3'b010);
            cycle();
        end
        chk("full_req_ready", 32'(bus.req_ready), 32'h0);
        drive(1'b1, 32'h5000, 32'hDEAD, 3'b010);
        repeat (3) cycle();
        chk("stall_head", bus.mem_wdata, 32'h100);
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        bus.mem_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            cycle();
            chk("drain_order", bus.mem_wdata, 32'h100 + 32'(i));
        end
        cycle();
        chk("drain_empty", 32'(bus.empty), 32'h1);

        // Steady stream: one in, one out every cycle across pointer wrap
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 32'h6000 + 32'(4 * i), 32'h900 + 32'(i), 3'b010);
            cycle();
            chk("stream_valid", 32'(bus.mem_valid), 32'h1);
            chk("stream_ready", 32'(bus.req_ready), 32'h1);
            chk("stream_head", bus.mem_wdata, 32'h900 + 32'(i));
        end
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        cycle();

        // Misaligned word store
        drive(1'b1, 32'h3001, 32'h11223344, 3'b010);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
`ifdef MISALIGN_TRAP_EN
        chk("mis_err", 32'(bus.misalign_err), 32'h1);
        chk("mis_dropped", 32'(bus.mem_valid), 32'h0);
        cycle();
        chk("mis_pulse_end", 32'(bus.misalign_err), 32'h0);
`else
        chk("mis_wstrb", 32'(bus.mem_wstrb), 32'hF);
        chk("mis_err", 32'(bus.misalign_err), 32'h0);
        chk("mis_addr", bus.mem_addr, 32'h3000);
        cycle();
`endif

        // Random traffic, with occasional mid-stream reset
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 99) < 60, $urandom(), $urandom(), 3'($urandom_range(0, 7)));
            bus.mem_ready = $urandom_range(0, 99) < 55;
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        repeat (2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
